// File: rtl/reg_alu_datapath.sv
// Execution datapath behind the multicycle control FSM: a register bank,
// latched A/B operands, a combinational ALU and the registered ALUOut.
module reg_alu_datapath #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             reset_wire,
    input  logic [2:0]       operacao,
    input  logic             writeReg,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic             load_en,
    input  logic [4:0]       load_addr,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_out_reg,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_PASSA = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_AND   = 3'b011,
        OP_OR    = 3'b100,
        OP_XOR   = 3'b101,
        OP_SLT   = 3'b110,
        OP_SLL   = 3'b111
    } alu_op_t;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_alu_out;

    logic [WIDTH-1:0] w_rs1_val;
    logic [WIDTH-1:0] w_rs2_val;
    logic [WIDTH-1:0] w_alu;
    alu_op_t          w_op;

    // x0 is hardwired: never written, and the read mux forces zero as well
    assign w_rs1_val = (rs1 == '0) ? '0 : r_regs[rs1];
    assign w_rs2_val = (rs2 == '0) ? '0 : r_regs[rs2];
    assign w_op      = alu_op_t'(operacao);

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_PASSA: w_alu = r_a;
            OP_ADD:   w_alu = r_a + r_b;
            OP_SUB:   w_alu = r_a - r_b;
            OP_AND:   w_alu = r_a & r_b;
            OP_OR:    w_alu = r_a | r_b;
            OP_XOR:   w_alu = r_a ^ r_b;
            OP_SLT:   w_alu[0] = ($signed(r_a) < $signed(r_b));
            OP_SLL:   w_alu = r_a << r_b[SHW-1:0];
            default:  w_alu = '0;
        endcase
    end

    // Reads use pre-edge bank contents; writeReg wins over the load port
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
        end else if (reset_wire) begin
            for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
        end else begin
            r_a       <= w_rs1_val;
            r_b       <= w_rs2_val;
            r_alu_out <= w_alu;
            if (writeReg) begin
                if (rd != '0) r_regs[rd] <= w_alu;
            end else if (load_en && (load_addr != '0)) begin
                r_regs[load_addr] <= load_data;
            end
        end
    end

    assign a_out       = r_a;
    assign b_out       = r_b;
    assign alu_result  = w_alu;
    assign alu_out_reg = r_alu_out;
    assign zero        = (w_alu == '0);

endmodule

// File: tb/tb_reg_alu_datapath.sv
// Scoreboard bench for reg_alu_datapath: expectations are queued with the
// stimulus and drained against the DUT outputs once they are due.
module tb_reg_alu_datapath;

    localparam int W = 64;
    localparam int SEL_A = 0, SEL_B = 1, SEL_ALU = 2, SEL_OUT = 3, SEL_Z = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         reset_wire;
    logic [2:0]   operacao;
    logic         writeReg;
    logic [4:0]   rs1, rs2, rd;
    logic         load_en;
    logic [4:0]   load_addr;
    logic [W-1:0] load_data;
    logic [W-1:0] a_out, b_out, alu_result, alu_out_reg;
    logic         zero;

    int n_checks = 0;
    int n_errors = 0;

    string        q_tag [$];
    int           q_sel [$];
    logic [W-1:0] q_exp [$];

    reg_alu_datapath #(.WIDTH(W), .NREGS(32)) dut (
        .CLK(CLK), .RST(RST), .reset_wire(reset_wire), .operacao(operacao),
        .writeReg(writeReg), .rs1(rs1), .rs2(rs2), .rd(rd),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .a_out(a_out), .b_out(b_out), .alu_result(alu_result),
        .alu_out_reg(alu_out_reg), .zero(zero)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [W-1:0] val);
        q_tag.push_back(tag);
        q_sel.push_back(sel);
        q_exp.push_back(val);
    endtask

    task automatic drain();
        string        t;
        int           s;
        logic [W-1:0] e;
        logic [W-1:0] obs;
        while (q_tag.size() > 0) begin
            t = q_tag.pop_front();
            s = q_sel.pop_front();
            e = q_exp.pop_front();
            case (s)
                SEL_A:   obs = a_out;
                SEL_B:   obs = b_out;
                SEL_ALU: obs = alu_result;
                SEL_OUT: obs = alu_out_reg;
                default: obs = {{(W-1){1'b0}}, zero};
            endcase
            check(t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        drain();
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    task automatic load(input logic [4:0] addr, input logic [W-1:0] data);
        writeReg  = 1'b0;
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] addr, input logic [W-1:0] val, input string tag);
        writeReg = 1'b0;
        load_en  = 1'b0;
        rs1      = addr;
        expect_out(tag, SEL_A, val);
        tick();
    endtask

    task automatic latch(input logic [4:0] a, input logic [4:0] b);
        writeReg = 1'b0;
        load_en  = 1'b0;
        operacao = 3'b000;
        rs1 = a;
        rs2 = b;
        tick();
    endtask

    task automatic expect_clear(input string pfx);
        expect_out({pfx, "_a"},    SEL_A,   '0);
        expect_out({pfx, "_b"},    SEL_B,   '0);
        expect_out({pfx, "_aout"}, SEL_OUT, '0);
        expect_out({pfx, "_alu"},  SEL_ALU, '0);
        expect_out({pfx, "_zero"}, SEL_Z,   64'd1);
    endtask

    initial begin
        RST = 1'b1; reset_wire = 1'b0; operacao = 3'b000; writeReg = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
        expect_clear("rst_init");
        repeat (2) @(posedge CLK);
        #1;
        drain();
        RST = 1'b0;

        // Asynchronous RST between edges
        load(5'd5, 64'd9);
        latch(5'd5, 5'd5);
        expect_out("pre_rst_aout", SEL_OUT, 64'd9);
        tick();
        #2 RST = 1'b1;
        expect_clear("rst_async");
        settle();
        #2 RST = 1'b0;
        read_reg(5'd5, 64'd0, "r5_after_rst");

        // Synchronous reset_wire, also blocking a same-cycle load
        load(5'd5, 64'd9);
        latch(5'd5, 5'd5);
        tick();
        reset_wire = 1'b1;
        load_en = 1'b1; load_addr = 5'd8; load_data = 64'd55;
        expect_out("rw_before_edge_a", SEL_A, 64'd9);
        settle();
        expect_clear("rw_sync");
        tick();
        reset_wire = 1'b0;
        load_en = 1'b0;
        read_reg(5'd5, 64'd0, "r5_after_rw");
        read_reg(5'd8, 64'd0, "r8_load_blocked");

        // Basic add: espera then soma
        load(5'd1, 64'd5);
        load(5'd2, 64'd7);
        rd = 5'd3;
        expect_out("add_a", SEL_A, 64'd5);
        expect_out("add_b", SEL_B, 64'd7);
        latch(5'd1, 5'd2);
        operacao = 3'b001; writeReg = 1'b1;
        expect_out("add_alu", SEL_ALU, 64'd12);
        settle();
        expect_out("add_aluout", SEL_OUT, 64'd12);
        tick();
        writeReg = 1'b0; operacao = 3'b000;
        read_reg(5'd3, 64'd12, "r3_sum");

        // x0 protection
        latch(5'd1, 5'd2);
        operacao = 3'b001; writeReg = 1'b1; rd = 5'd0;
        tick();
        writeReg = 1'b0; operacao = 3'b000;
        read_reg(5'd0, 64'd0, "r0_alu_write");
        load(5'd0, 64'hFF);
        read_reg(5'd0, 64'd0, "r0_load_write");

        // writeReg beats load_en at the same address
        latch(5'd1, 5'd2);
        operacao = 3'b001; writeReg = 1'b1; rd = 5'd4;
        load_en = 1'b1; load_addr = 5'd4; load_data = 64'd99;
        tick();
        writeReg = 1'b0; load_en = 1'b0; operacao = 3'b000;
        read_reg(5'd4, 64'd12, "r4_priority");

        // Arithmetic boundaries
        latch(5'd1, 5'd2);
        operacao = 3'b010;
        expect_out("sub_alu",  SEL_ALU, 64'hFFFF_FFFF_FFFF_FFFE);
        expect_out("sub_zero", SEL_Z,   64'd0);
        settle();
        operacao = 3'b110;
        expect_out("slt_5_7", SEL_ALU, 64'd1);
        settle();
        operacao = 3'b011;
        expect_out("and_5_7", SEL_ALU, 64'd5);
        settle();
        operacao = 3'b101;
        expect_out("xor_5_7", SEL_ALU, 64'd2);
        settle();
        load(5'd9,  64'hFFFF_FFFF_FFFF_FFFF);
        load(5'd10, 64'd1);
        latch(5'd9, 5'd10);
        operacao = 3'b001;
        expect_out("add_wrap",      SEL_ALU, 64'd0);
        expect_out("add_wrap_zero", SEL_Z,   64'd1);
        settle();
        operacao = 3'b110;
        expect_out("slt_signed", SEL_ALU, 64'd1);
        settle();
        operacao = 3'b100;
        expect_out("or_all", SEL_ALU, 64'hFFFF_FFFF_FFFF_FFFF);
        settle();
        load(5'd11, 64'd1);
        load(5'd12, 64'd65);
        latch(5'd11, 5'd12);
        operacao = 3'b111;
        expect_out("sll_mask", SEL_ALU, 64'd2);
        settle();
        operacao = 3'b000;

        // RST held across a soma edge cancels the write
        latch(5'd1, 5'd2);
        operacao = 3'b001; writeReg = 1'b1; rd = 5'd6;
        #2 RST = 1'b1;
        tick();
        RST = 1'b0;
        writeReg = 1'b0; operacao = 3'b000;
        read_reg(5'd6, 64'd0, "r6_cancelled");

        // Read during write: old value first, new value one edge later
        load(5'd7, 64'd21);
        rs1 = 5'd7;
        load_en = 1'b1; load_addr = 5'd7; load_data = 64'd33;
        expect_out("rdw_old", SEL_A, 64'd21);
        tick();
        load_en = 1'b0;
        expect_out("rdw_new", SEL_A, 64'd33);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_alu_datapath.md
Name: reg_alu_datapath

Overview:
- Execution datapath directly downstream of the multicycle control FSM.
- Consumes the FSM's reset_wire, operacao and writeReg outputs.
- Contains a 32-entry register bank, latched operand registers A/B, a combinational ALU and a registered ALU output (ALUOut).
- A 2-cycle FSM sequence executes one register-register operation: an "espera" cycle latches the operands, then a "soma" cycle computes the result and writes it back.

Parameters:
- WIDTH, 64, data width of registers, ALU and load port.
- NREGS, 32, number of architectural registers; address width is 5 bits, fixed.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  asynchronous active-high reset
- reset_wire  input  1  synchronous clear request from the control FSM
- operacao  input  3  ALU operation select from the control FSM
- writeReg  input  1  register-bank write enable from the control FSM
- rs1  input  5  source register 1 address
- rs2  input  5  source register 2 address
- rd  input  5  destination register address
- load_en  input  1  test/boot write enable
- load_addr  input  5  test/boot write address
- load_data  input  WIDTH  test/boot write data
- a_out  output  WIDTH  operand register A
- b_out  output  WIDTH  operand register B
- alu_result  output  WIDTH  combinational ALU result of A, B and operacao
- alu_out_reg  output  WIDTH  ALUOut register, previous cycle's alu_result
- zero  output  1  alu_result == 0, combinational

Behaviour:
- Reset (RST, asynchronous): all NREGS registers, A, B and ALUOut go to 0 immediately. Resulting outputs: a_out = b_out = alu_out_reg = 0; alu_result = 0 (op 000 = pass A); zero = 1.
- reset_wire = 1 at a rising edge: same clear as RST, applied synchronously. It overrides writeReg, load_en and operand latching in that cycle.
- Operand latching (every rising edge, no reset active):
  - A <= R[rs1] and B <= R[rs2].
  - Reads see the pre-edge contents; there is no write-to-read bypass.
  - A value written in cycle N is readable into A/B at the edge ending cycle N+1.
- ALUOut <= alu_result every rising edge when not in reset.
- ALU encoding (operacao), all results mod 2^WIDTH, no overflow flag:
  - 000 pass A
  - 001 ADD A+B
  - 010 SUB A-B
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110 SLT: signed A<B gives 1, else 0, zero-extended
  - 111 SLL: A << B[log2(WIDTH)-1:0]
- Write port, at the rising edge:
  - If writeReg = 1 and rd != 0: R[rd] <= alu_result (current-cycle value computed from the latched A/B).
  - Else if load_en = 1 and load_addr != 0: R[load_addr] <= load_data.
  - writeReg has priority over load_en whenever both are asserted, regardless of address.
  - Only one register is written per cycle.
- R[0] reads as 0 always. Writes to address 0 are silently discarded.
- Latency for the FSM sequence reset -> espera -> soma:
  - espera edge latches R[rs1]/R[rs2].
  - In the soma cycle alu_result = A+B; the soma edge writes R[rd] and ALUOut.
  - Total: 2 cycles from rs1/rs2 presentation to register update.
- RST asserted mid-sequence (e.g. during soma) cancels the pending write. Nothing is written.
- Inputs are sampled only at rising edges; no combinational path exists from rs1/rs2 to alu_result.

Test Plan:
- Reset and clear:
  - Load R5 = 9, then pulse RST between edges -> a_out, b_out, alu_out_reg = 0 immediately, zero = 1, and R5 reads 0 on the next latch.
  - Repeat with a reset_wire pulse -> the same clear, taking effect at the edge.
- Basic add:
  - Load R1 = 5 and R2 = 7. Then rs1 = 1, rs2 = 2, rd = 3.
  - Cycle 1: operacao = 0, writeReg = 0 -> A = 5, B = 7 after the edge.
  - Cycle 2: operacao = 001, writeReg = 1 -> alu_result = 12 in-cycle; R3 = 12 and alu_out_reg = 12 after the edge.
  - Re-latch with rs1 = 3 -> a_out = 12.
- x0 protection:
  - writeReg = 1, rd = 0, A+B = 12 -> R0 still reads 0.
  - load_en = 1, load_addr = 0, load_data = 0xFF -> R0 still reads 0.
- Write priority:
  - Same cycle: writeReg = 1, rd = 4, alu_result = 12, plus load_en = 1, load_addr = 4, load_data = 99 -> R4 = 12.
- Arithmetic boundaries:
  - A = 5, B = 7, SUB -> 0xFFFF_FFFF_FFFF_FFFE.
  - SLT on the same operands -> 1.
  - A = 0xFFFF_FFFF_FFFF_FFFF, B = 1, ADD -> 0 with zero = 1.
  - SLL with A = 1, B = 65 -> 2 (shift amount masked to 6 bits).
- Reset mid-operation and read-during-write:
  - Assert RST during a soma cycle with rd = 6 -> R6 stays 0.
  - Write R7 while rs1 = 7 in the same cycle -> A gets the old R7 value; the new value appears one edge later.
